// File: rtl/seg_scan.sv
// Scan controller for a common-anode seven-segment display. Each scan slot
// presents one digit's nibble and its active-low anode. The value is snapshotted
// once per frame, and leading zeros can optionally be blanked.
module seg_scan #(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [4*NDIG-1:0]                      value,
    input  logic                                   blank_lz,
    input  logic                                   enable,
    output logic [3:0]                             nibble,
    output logic [NDIG-1:0]                        an,
    output logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] dig_idx,
    output logic                                   frame_start
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);
    localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0]     cnt;
    logic [4*NDIG-1:0] shadow;
    logic              enable_q;

    logic              tick;
    logic              wrap;
    logic [IW-1:0]     next_idx;
    logic [4*NDIG-1:0] snap;
    logic              zrun;
    logic [NDIG-1:0]   lead_zero;
    logic [3:0]        nib_next;
    logic [NDIG-1:0]   an_next;

    // The digit-0 slot reads the live value, because that is exactly what the
    // shadow is about to capture on this edge.
    always_comb begin
        tick     = (cnt == CMAX);
        wrap     = tick && (dig_idx == LAST);
        next_idx = dig_idx;
        if (tick) next_idx = wrap ? '0 : dig_idx + IW'(1);
        snap = wrap ? value : shadow;

        zrun      = 1'b1;
        lead_zero = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zrun         = zrun & (snap[4*i +: 4] == 4'h0);
            lead_zero[i] = zrun;
        end

        nib_next = '0;
        an_next  = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (next_idx == IW'(i)) begin
                nib_next = snap[4*i +: 4];
                if (enable && !(blank_lz && (i != 0) && lead_zero[i]))
                    an_next[i] = 1'b0;
            end
        end
    end

    // Outside a tick, the anode is touched only to follow enable: it is forced
    // dark while enable is low, and the current digit is re-lit on a rising enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            dig_idx     <= LAST;
            shadow      <= '0;
            nibble      <= '0;
            an          <= '1;
            frame_start <= 1'b0;
            enable_q    <= 1'b1;
        end else begin
            enable_q    <= enable;
            cnt         <= tick ? '0 : cnt + CW'(1);
            frame_start <= wrap;
            if (tick) begin
                dig_idx <= next_idx;
                nibble  <= nib_next;
                an      <= an_next;
                if (wrap) shadow <= value;
            end else if (!enable) begin
                an <= '1;
            end else if (!enable_q) begin
                an <= an_next;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with NDIG=4 and SCAN_DIV=4. It covers the scan
// order, leading-zero blanking, the frame snapshot, enable gating and
// asynchronous reset.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        blank_lz = 1'b0;
    logic        enable = 1'b1;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic [1:0]  dig_idx;
    logic        frame_start;

    int vec_count = 0;
    int miss_count = 0;

    seg_scan #(.NDIG(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .blank_lz(blank_lz),
        .enable(enable), .nibble(nibble), .an(an), .dig_idx(dig_idx),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset with the given inputs applied, then release between edges, so
    // that the next rising edge is edge 1.
    task automatic start(input logic [15:0] v, input logic bl);
        @(negedge clk);
        rst_n = 1'b0;
        value = v;
        blank_lz = bl;
        enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec_count++;
        if ({an, nibble, frame_start, dig_idx} !== {4'b1111, 4'h0, 1'b0, 2'd3}) begin
            miss_count++;
            $display("[TB] FAIL reset_state got an=%b nib=%h fs=%b idx=%0d want an=1111 nib=0 fs=0 idx=3",
                     an, nibble, frame_start, dig_idx);
        end
    endtask

    task automatic test_scan;
        logic [3:0] exp_an [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] exp_nib [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        start(16'h1234, 1'b0);
        edges(3);
        vec_count++;
        if (an !== 4'b1111) begin
            miss_count++;
            $display("[TB] FAIL scan_pre_tick got an=%b want 1111", an);
        end
        for (int s = 0; s < 5; s++) begin
            edges(s == 0 ? 1 : 4);
            vec_count++;
            if ({an, nibble, frame_start} !== {exp_an[s%4], exp_nib[s%4], (s%4) == 0}) begin
                miss_count++;
                $display("[TB] FAIL scan_slot%0d got an=%b nib=%h fs=%b want an=%b nib=%h fs=%b",
                         s, an, nibble, frame_start, exp_an[s%4], exp_nib[s%4], (s%4) == 0);
            end
        end
        edges(1);
        vec_count++;
        if (frame_start !== 1'b0) begin
            miss_count++;
            $display("[TB] FAIL scan_fs_width got fs=%b want 0", frame_start);
        end
    endtask

    task automatic test_blank_0050;
        logic [3:0] exp_an [4]  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        logic [3:0] exp_nib [4] = '{4'h0, 4'h5, 4'h0, 4'h0};
        start(16'h0050, 1'b1);
        for (int s = 0; s < 4; s++) begin
            edges(s == 0 ? 4 : 4);
            vec_count++;
            if ({an, nibble} !== {exp_an[s], exp_nib[s]}) begin
                miss_count++;
                $display("[TB] FAIL blank0050_slot%0d got an=%b nib=%h want an=%b nib=%h",
                         s, an, nibble, exp_an[s], exp_nib[s]);
            end
        end
    endtask

    task automatic test_blank_zero;
        logic [3:0] exp_an [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        start(16'h0000, 1'b1);
        for (int s = 0; s < 4; s++) begin
            edges(4);
            vec_count++;
            if ({an, nibble} !== {exp_an[s], 4'h0}) begin
                miss_count++;
                $display("[TB] FAIL blankzero_slot%0d got an=%b nib=%h want an=%b nib=0",
                         s, an, nibble, exp_an[s]);
            end
        end
    endtask

    task automatic test_tearing;
        start(16'h1111, 1'b0);
        edges(9);
        value = 16'h2222;
        for (int s = 2; s < 8; s++) begin
            edges(s == 2 ? 3 : 4);
            vec_count++;
            if (nibble !== ((s < 4) ? 4'h1 : 4'h2)) begin
                miss_count++;
                $display("[TB] FAIL tearing_slot%0d got nib=%h want %h",
                         s, nibble, (s < 4) ? 4'h1 : 4'h2);
            end
        end
    endtask

    task automatic test_enable;
        start(16'h1234, 1'b0);
        edges(8);
        enable = 1'b0;
        edges(1);
        vec_count++;
        if ({an, nibble} !== {4'b1111, 4'h3}) begin
            miss_count++;
            $display("[TB] FAIL enable_off got an=%b nib=%h want an=1111 nib=3", an, nibble);
        end
        edges(3);
        vec_count++;
        if ({an, nibble, frame_start, dig_idx} !== {4'b1111, 4'h2, 1'b0, 2'd2}) begin
            miss_count++;
            $display("[TB] FAIL enable_tick_off got an=%b nib=%h fs=%b idx=%0d want an=1111 nib=2 fs=0 idx=2",
                     an, nibble, frame_start, dig_idx);
        end
        edges(2);
        enable = 1'b1;
        edges(1);
        vec_count++;
        if ({an, nibble} !== {4'b1011, 4'h2}) begin
            miss_count++;
            $display("[TB] FAIL enable_relight got an=%b nib=%h want an=1011 nib=2", an, nibble);
        end
        edges(1);
        vec_count++;
        if ({an, nibble, dig_idx} !== {4'b0111, 4'h1, 2'd3}) begin
            miss_count++;
            $display("[TB] FAIL enable_next_slot got an=%b nib=%h idx=%0d want an=0111 nib=1 idx=3",
                     an, nibble, dig_idx);
        end
        edges(4);
        vec_count++;
        if ({an, nibble, frame_start, dig_idx} !== {4'b1110, 4'h4, 1'b1, 2'd0}) begin
            miss_count++;
            $display("[TB] FAIL enable_frame got an=%b nib=%h fs=%b idx=%0d want an=1110 nib=4 fs=1 idx=0",
                     an, nibble, frame_start, dig_idx);
        end
    endtask

    task automatic test_reset_mid;
        start(16'h1234, 1'b0);
        edges(13);
        #2;
        rst_n = 1'b0;
        #1;
        vec_count++;
        if ({an, nibble, dig_idx} !== {4'b1111, 4'h0, 2'd3}) begin
            miss_count++;
            $display("[TB] FAIL reset_mid got an=%b nib=%h idx=%0d want an=1111 nib=0 idx=3",
                     an, nibble, dig_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        edges(3);
        vec_count++;
        if (an !== 4'b1111) begin
            miss_count++;
            $display("[TB] FAIL reset_mid_wait got an=%b want 1111", an);
        end
        edges(1);
        vec_count++;
        if ({an, nibble, frame_start} !== {4'b1110, 4'h4, 1'b1}) begin
            miss_count++;
            $display("[TB] FAIL reset_mid_first got an=%b nib=%h fs=%b want an=1110 nib=4 fs=1",
                     an, nibble, frame_start);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank_0050();
        test_blank_zero();
        test_tearing();
        test_enable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scan controller for the chronometer's common-anode seven-segment display. It holds a `4*NDIG`-bit packed hex value and presents one nibble at a time on `nibble`, which feeds the hex-to-segment decoder. It also drives the matching active-low anode enable, so the shared segment bus lights one digit per scan slot. It snapshots the value once per frame to prevent tearing and optionally blanks leading zeros.

## Interface
- `NDIG`, 4, number of digits scanned; legal 1..8.
- `SCAN_DIV`, 50000, clock cycles per digit slot; legal ≥ 2.
- `clk` input 1: system clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `value` input 4*NDIG: packed hex digits; `value[3:0]` is digit 0 (rightmost).
- `blank_lz` input 1: 1 = suppress leading zero digits.
- `enable` input 1: 0 = all anodes off; scanning continues.
- `nibble` output 4: hex code of the current digit, to the segment decoder.
- `an` output NDIG: active-low anode enables; at most one bit is low.
- `dig_idx` output max(1,$clog2(NDIG)): index of the current digit.
- `frame_start` output 1: one-cycle pulse when digit 0 slot begins.

## Operation
- Prescaler `cnt` runs 0..SCAN_DIV-1 and wraps. `tick` = (cnt == SCAN_DIV-1).
- On `tick`, `dig_idx` advances: NDIG-1 → 0, otherwise +1.
- Snapshot: on a tick whose next index is 0, `shadow <= value`.
  - Digit-0 outputs for that slot use the live `value`, which equals the new shadow.
  - All other slots use `shadow`.
  - A `value` change mid-frame is invisible until the next frame.
- Blanking: digit i (i ≥ 1) is blanked when `blank_lz`=1 and nibbles NDIG-1..i of the frame's snapshot are all zero.
  - Digit 0 is never blanked.
  - A blanked digit keeps `nibble` driven with its code, but its anode stays high.
- All outputs are registered and update together on the tick edge:
  - `nibble` <= snapshot nibble of the next index.
  - `an` <= all ones, with bit[next] low only if `enable`=1 and the digit is not blanked.
  - `frame_start` <= 1 if the next index is 0, else 0.
- `enable` is sampled every cycle. Deasserting it forces `an` all-high on the next edge. Reasserting it re-lights the current digit on the next edge, if that digit is not blanked. Counter and index are unaffected.

## Timing
- Reset values: `cnt`=0, `dig_idx`=NDIG-1, `shadow`=0, `nibble`=0, `an`=all ones, `frame_start`=0.
- After `rst_n` rises, the first tick is at the SCAN_DIV-th rising edge.
  - At that edge: index goes to 0, the snapshot is taken, and digit 0 lights.
  - `frame_start` is high for that one cycle.
- Each digit is lit for exactly SCAN_DIV cycles. Frame period is NDIG*SCAN_DIV cycles.
- `frame_start` is high for exactly 1 cycle per frame, coincident with the cycle in which `an` first shows digit 0.
- There is no latency between `nibble` and `an`: both change on the same edge.
- NDIG=1: every tick is a frame start, `an` is 1 bit, and `dig_idx` is 1 bit held at 0.
- Reset asserted mid-slot: all state returns to reset values immediately (asynchronous), and `an` goes all-high without waiting for a clock.
- `tick` coinciding with an `enable` change: the new `an` value uses the `enable` sampled on that edge.

## Test plan
- SCAN_DIV=4, NDIG=4, value=16'h1234, blank_lz=0, enable=1, release reset.
  - At edge 4: `an`=4'b1110, `nibble`=4, `frame_start`=1.
  - Edges 8/12/16: `an`=1101/1011/0111, `nibble`=3/2/1.
  - Edge 20: back to digit 0 with `frame_start`=1.
- value=16'h0050, blank_lz=1: digit slots 3 and 2 show `an`=4'b1111; slot 1 shows `an`=1101 with `nibble`=5; slot 0 shows `an`=1110 with `nibble`=0.
- value=16'h0000, blank_lz=1: only slot 0 lights (`an`=1110, `nibble`=0); the other three slots give `an`=1111.
- Tearing: start with value=16'h1111, change it to 16'h2222 during slot 1. Slots 2 and 3 still give `nibble`=1. The next frame gives `nibble`=2 in all slots.
- Toggle `enable` low for 6 cycles mid-slot: `an`=1111 from the next edge. `dig_idx` and the `frame_start` cadence are unchanged. `an` restores one edge after re-enable.
- Assert `rst_n`=0 during slot 2: `an`=1111 and `nibble`=0 immediately. After release, digit 0 lights at the 4th edge.
